// File: rtl/prescaler_selector.sv
// WS2812 bit-timing sequencer: turns each data bit into a high/low
// pulse pair timed by external short/long duration timers.
module prescaler_selector (
  input  logic clk,
  input  logic rstn,
  input  logic bit_to_transmit,
  input  logic all_bits_shifted,
  input  logic reset_finish,
  output logic new_bit_rqst,
  output logic l_time_wait,
  input  logic l_time_measured,
  output logic s_time_wait,
  input  logic s_time_measured,
  output logic led_stripe_pin
);

  typedef enum logic [2:0] {
    LOAD,
    HIGH,
    LOW,
    REQ,
    RESET
  } state_t;

  state_t state, next_state;
  logic   bit_q;
  logic   pin_q;
  logic   high_done;
  logic   low_done;

  // a '1' bit is long-high/short-low, a '0' bit the reverse
  assign high_done = bit_q ? l_time_measured : s_time_measured;
  assign low_done  = bit_q ? s_time_measured : l_time_measured;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= LOAD;
      bit_q <= 1'b0;
      pin_q <= 1'b0;
    end else begin
      state <= next_state;
      pin_q <= (next_state == HIGH);
      if (state == LOAD)
        bit_q <= bit_to_transmit;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      LOAD:  next_state = HIGH;
      HIGH:  if (high_done) next_state = LOW;
      LOW: begin
        if (low_done)
          next_state = all_bits_shifted ? RESET : REQ;
      end
      REQ:   next_state = LOAD;
      RESET: if (reset_finish) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_comb begin
    new_bit_rqst = 1'b0;
    l_time_wait  = 1'b0;
    s_time_wait  = 1'b0;
    unique case (state)
      HIGH: begin
        l_time_wait = bit_q;
        s_time_wait = !bit_q;
      end
      LOW: begin
        l_time_wait = !bit_q;
        s_time_wait = bit_q;
      end
      REQ:   new_bit_rqst = 1'b1;
      default: ;
    endcase
  end

  assign led_stripe_pin = pin_q;

endmodule

// File: tb/tb_prescaler_selector.sv
// Bench for prescaler_selector: directed handshake scenarios plus
// randomized bit streams checked against a pulse-width model.
module tb_prescaler_selector;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic bit_to_transmit = 1'b0;
  logic all_bits_shifted = 1'b0;
  logic reset_finish = 1'b0;
  logic new_bit_rqst;
  logic l_time_wait;
  logic l_time_measured = 1'b0;
  logic s_time_wait;
  logic s_time_measured = 1'b0;
  logic led_stripe_pin;

  int tests = 0;
  int fails = 0;

  prescaler_selector dut (
    .clk              (clk),
    .rstn             (rstn),
    .bit_to_transmit  (bit_to_transmit),
    .all_bits_shifted (all_bits_shifted),
    .reset_finish     (reset_finish),
    .new_bit_rqst     (new_bit_rqst),
    .l_time_wait      (l_time_wait),
    .l_time_measured  (l_time_measured),
    .s_time_wait      (s_time_wait),
    .s_time_measured  (s_time_measured),
    .led_stripe_pin   (led_stripe_pin)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_s();
    s_time_measured = 1'b1;
    tick();
    s_time_measured = 1'b0;
  endtask

  task automatic pulse_l();
    l_time_measured = 1'b1;
    tick();
    l_time_measured = 1'b0;
  endtask

  // expects {pin, s_wait, l_wait, rqst}
  task automatic chk(string name, logic [3:0] exp);
    logic [3:0] got;
    got = {led_stripe_pin, s_time_wait, l_time_wait, new_bit_rqst};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: pin/s/l/rqst got %b want %b", name, got, exp);
    end
  endtask

  task automatic restart(logic b);
    @(negedge clk);
    rstn = 1'b0;
    all_bits_shifted = 1'b0;
    reset_finish = 1'b0;
    s_time_measured = 1'b0;
    l_time_measured = 1'b0;
    bit_to_transmit = b;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    tick();
    chk("reset_state", 4'b0000);
  endtask

  task automatic test_bit0();
    restart(1'b0);
    chk("bit0_high", 4'b1100);
    tick();
    tick();
    chk("bit0_high_hold", 4'b1100);
    pulse_s();
    chk("bit0_low", 4'b0010);
    pulse_l();
    chk("bit0_req", 4'b0001);
    tick();
    chk("bit0_load", 4'b0000);
    tick();
    chk("bit0_next_high", 4'b1100);
  endtask

  task automatic test_bit1();
    restart(1'b1);
    chk("bit1_high", 4'b1010);
    pulse_l();
    chk("bit1_low", 4'b0100);
    pulse_s();
    chk("bit1_req", 4'b0001);
  endtask

  task automatic test_wrong_type();
    restart(1'b0);
    pulse_l();
    chk("wrong_type_ignored", 4'b1100);
    reset_finish = 1'b1;
    tick();
    reset_finish = 1'b0;
    chk("reset_finish_ignored", 4'b1100);
    pulse_s();
    chk("wrong_type_then_low", 4'b0010);
  endtask

  task automatic test_frame_end();
    int bad;
    restart(1'b0);
    pulse_s();
    all_bits_shifted = 1'b1;
    pulse_l();
    all_bits_shifted = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if ({led_stripe_pin, s_time_wait, l_time_wait, new_bit_rqst} !== 4'b0000)
        bad++;
      s_time_measured = i[0];
      l_time_measured = !i[0];
      tick();
    end
    s_time_measured = 1'b0;
    l_time_measured = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_hold: %0d bad cycles, want 0", bad);
    end
    reset_finish = 1'b1;
    tick();
    reset_finish = 1'b0;
    chk("reset_to_load", 4'b0000);
    tick();
    chk("reset_load_high", 4'b1100);
  endtask

  task automatic test_mid_reset();
    restart(1'b0);
    chk("mid_pre", 4'b1100);
    #2 rstn = 1'b0;
    #1 chk("mid_async_clear", 4'b0000);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("mid_restart", 4'b1100);
  endtask

  // model: each bit gives a high run of its high duration, then a low
  // run of its low duration plus two cycles of overhead (REQ, LOAD)
  task automatic test_random_stream();
    for (int it = 0; it < 5; it++) begin
      int n, sd, ld, idx, rq, hr, lr, sc, lc, cyc;
      logic bits[$];
      int exp_hi[$];
      int exp_lo[$];
      int obs_hi[$];
      int obs_lo[$];
      logic prev;
      if (it == 0) begin
        bits = '{1'b1, 1'b0, 1'b1};
      end else begin
        bits = {};
        n = $urandom_range(2, 8);
        for (int k = 0; k < n; k++)
          bits.push_back(1'($urandom_range(0, 1)));
      end
      n = bits.size();
      sd = $urandom_range(1, 4);
      ld = sd + $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        exp_hi.push_back(bits[k] ? ld : sd);
        if (k < n - 1)
          exp_lo.push_back((bits[k] ? sd : ld) + 2);
      end
      @(negedge clk);
      rstn = 1'b0;
      s_time_measured = 1'b0;
      l_time_measured = 1'b0;
      reset_finish = 1'b0;
      idx = 0;
      bit_to_transmit = bits[0];
      all_bits_shifted = (n == 1);
      tick();
      rstn = 1'b1;
      rq = 0; hr = 0; lr = 0; sc = 0; lc = 0; cyc = 0;
      prev = 1'b0;
      while (cyc < 1000 && !(obs_hi.size() == n && lr >= 10)) begin
        tick();
        cyc++;
        if (new_bit_rqst) begin
          rq++;
          idx++;
          bit_to_transmit = (idx < n) ? bits[idx] : 1'b0;
          all_bits_shifted = (idx == n - 1);
        end
        if (led_stripe_pin) begin
          if (!prev && obs_hi.size() > 0)
            obs_lo.push_back(lr);
          hr = prev ? hr + 1 : 1;
        end else begin
          if (prev)
            obs_hi.push_back(hr);
          lr = prev ? 1 : lr + 1;
        end
        prev = led_stripe_pin;
        if (s_time_wait) begin
          sc++;
          s_time_measured = (sc == sd);
        end else begin
          sc = 0;
          s_time_measured = 1'b0;
        end
        if (l_time_wait) begin
          lc++;
          l_time_measured = (lc == ld);
        end else begin
          lc = 0;
          l_time_measured = 1'b0;
        end
      end
      s_time_measured = 1'b0;
      l_time_measured = 1'b0;
      tests++;
      if (cyc >= 1000) begin
        fails++;
        $display("FAIL stream%0d_timeout: %0d highs seen, want %0d",
                 it, obs_hi.size(), n);
      end
      tests++;
      if (rq != n - 1) begin
        fails++;
        $display("FAIL stream%0d_rqst: got %0d want %0d", it, rq, n - 1);
      end
      for (int k = 0; k < n; k++) begin
        tests++;
        if (k >= obs_hi.size() || obs_hi[k] != exp_hi[k]) begin
          fails++;
          $display("FAIL stream%0d_high%0d: got %0d want %0d", it, k,
                   (k < obs_hi.size()) ? obs_hi[k] : -1, exp_hi[k]);
        end
      end
      for (int k = 0; k < n - 1; k++) begin
        tests++;
        if (k >= obs_lo.size() || obs_lo[k] != exp_lo[k]) begin
          fails++;
          $display("FAIL stream%0d_low%0d: got %0d want %0d", it, k,
                   (k < obs_lo.size()) ? obs_lo[k] : -1, exp_lo[k]);
        end
      end
      chk("stream_in_reset", 4'b0000);
    end
  endtask

  initial begin
    test_reset();
    test_bit0();
    test_bit1();
    test_wrong_type();
    test_frame_end();
    test_mid_reset();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prescaler_selector.md
Name: prescaler_selector

Overview:
- Bit-timing sequencer for a WS2812-style single-wire LED stripe.
- Converts each serial data bit from the upstream shift register into a high/low pulse pair on led_stripe_pin, using two external duration timers (short and long) through a wait/measured handshake.
- After the last bit of a frame, holds the line low for the latch/reset period, then resumes.
- Sits between the pixel shift register and the stripe output pin.

Parameters:
- None. All durations come from the external timers.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rstn  input  1  asynchronous active-low reset
- bit_to_transmit  input  1  current data bit from the upstream shift register
- all_bits_shifted  input  1  high when the bit just sent was the last bit of the frame
- reset_finish  input  1  one-cycle pulse; the stripe reset/latch period has elapsed
- new_bit_rqst  output  1  one-cycle pulse; upstream shifts to the next bit
- l_time_wait  output  1  level; requests the long-duration timer to run
- l_time_measured  input  1  one-cycle pulse; long duration elapsed
- s_time_wait  output  1  level; requests the short-duration timer to run
- s_time_measured  input  1  one-cycle pulse; short duration elapsed
- led_stripe_pin  output  1  serial output to the stripe

Behaviour:
- Moore FSM with states LOAD, HIGH, LOW, REQ, RESET.
- All outputs decode from registered state only: no combinational input-to-output paths.
- led_stripe_pin comes from a register.
- Internal register bit_q holds the latched data bit.
- rstn low (asynchronous) forces:
  - state = LOAD, bit_q = 0
  - led_stripe_pin = 0, s_time_wait = 0, l_time_wait = 0, new_bit_rqst = 0
- LOAD:
  - Outputs all 0.
  - Unconditionally latches bit_q <= bit_to_transmit and moves to HIGH next edge (1-cycle state).
- HIGH:
  - Pin = 1.
  - bit_q = 0: s_time_wait = 1; exits on s_time_measured.
  - bit_q = 1: l_time_wait = 1; exits on l_time_measured.
  - On the exiting pulse, moves to LOW.
- LOW:
  - Pin = 0.
  - bit_q = 0: l_time_wait = 1; exits on l_time_measured.
  - bit_q = 1: s_time_wait = 1; exits on s_time_measured.
  - On the exiting pulse: RESET if all_bits_shifted = 1 (sampled that same edge), otherwise REQ.
- REQ:
  - Pin = 0, new_bit_rqst = 1 for exactly one cycle.
  - Next state: LOAD.
- RESET:
  - Pin = 0, both waits 0.
  - Holds until reset_finish = 1, then goes to LOAD.
  - No new_bit_rqst: upstream presents the first bit of the next frame itself.
- Handshake rules:
  - Exactly one wait output is high in HIGH/LOW; none in other states.
  - A wait drops in the cycle after its measured pulse is sampled.
  - A measured pulse of the non-requested type is ignored.
  - Measured pulses outside HIGH/LOW are ignored.
  - reset_finish outside RESET is ignored.
  - A measured pulse held for several cycles advances only one phase per edge. It may advance HIGH→LOW and then LOW→next only if it is the type that LOW is waiting for (only reachable when the timers misbehave; accepted).
- Timing:
  - rstn deasserts → first edge: LOAD→HIGH; pin = 1 and the wait asserts after that edge.
  - Per-bit overhead is 2 clk cycles (LOAD + REQ) beyond the timer durations.
  - bit_to_transmit is sampled only in LOAD.
  - all_bits_shifted is sampled only at the LOW exit.
- Reset mid-operation returns to LOAD immediately with pin low and both waits low.

Test Plan:
- bit_to_transmit = 0, release rstn → after 1 edge pin = 1, s_time_wait = 1, l_time_wait = 0. Pulse s_time_measured 1 cycle (2 cycles later) → next edge pin = 0, s_time_wait = 0, l_time_wait = 1. Pulse l_time_measured → REQ: new_bit_rqst high exactly 1 cycle, then LOAD.
- bit_to_transmit = 1 → HIGH asserts l_time_wait; LOW asserts s_time_wait. Pin high only between the first wait rise and the l_time_measured edge.
- all_bits_shifted = 1 at LOW exit → no new_bit_rqst; pin stays 0 and waits stay 0 for 20 cycles. Pulse reset_finish → LOAD, then HIGH on the following edge.
- Wrong-type pulse: in HIGH with bit 0, pulse l_time_measured → no state change, s_time_wait stays 1.
- rstn asserted during HIGH (pin = 1) → pin, waits and new_bit_rqst go 0 asynchronously. On release, the sequence restarts from LOAD.
- Stream of 3 bits 1,0,1 with all_bits_shifted on the third → exactly 2 new_bit_rqst pulses, then RESET state.
